// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, zero-register constant and address-width helper for regfile_mp
package regfile_pkg;
    localparam int ZERO_REG = 0;
    typedef logic [31:0] data_t;
    typedef logic [4:0] addr_t;
    function automatic int addr_bits(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one read port with forwarding, hazard flag and optional parity check (REGFILE_PARITY_EN)
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_WR = 2
) (
    input  logic                     rst,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        raddr,
    input  logic [DATA_W-1:0]        sdata,
`ifdef REGFILE_PARITY_EN
    input  logic                     spar,
    output logic                     rperr,
`endif
    input  logic                     pend,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rbusy
);
    logic              fwd;
    logic [DATA_W-1:0] fdata;
    logic              live;
    always_comb begin
        fwd   = 1'b0;
        fdata = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (we[k] && waddr[k*ADDR_W +: ADDR_W] == raddr) begin
                fwd   = 1'b1;
                fdata = wdata[k*DATA_W +: DATA_W];
            end
        end
    end
    assign live  = !rst && re && raddr != ADDR_W'(ZERO_REG);
    assign rdata = !live ? '0 : fwd ? fdata : sdata;
    assign rbusy = live && pend && !fwd;
`ifdef REGFILE_PARITY_EN
    assign rperr = live && !fwd && ((^sdata) != spar);
`endif
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write forwarding and pending-write scoreboard; REGFILE_PARITY_EN adds parity
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = addr_bits(DEPTH),
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
`ifdef REGFILE_PARITY_EN
    output logic [NUM_RD-1:0]        rperr,
`endif
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [DEPTH-1:0]         pend
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend_nxt;
`ifdef REGFILE_PARITY_EN
    logic [DEPTH-1:0]  par;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef REGFILE_PARITY_EN
            par <= '0;
`endif
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (we[k] && waddr[k*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG)) begin
                    mem[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
`ifdef REGFILE_PARITY_EN
                    par[waddr[k*ADDR_W +: ADDR_W]] <= ^wdata[k*DATA_W +: DATA_W];
`endif
                end
            end
        end
    end
    always_comb begin
        pend_nxt = pend;
        for (int k = 0; k < NUM_WR; k++)
            if (we[k]) pend_nxt[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
        if (iss_valid) pend_nxt[iss_addr] = 1'b1;
        pend_nxt[ZERO_REG] = 1'b0;
    end
    always_ff @(posedge clk) pend <= rst ? '0 : pend_nxt;
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_rd (
            .rst   (rst),
            .re    (re[j]),
            .raddr (raddr[j*ADDR_W +: ADDR_W]),
            .sdata (mem[raddr[j*ADDR_W +: ADDR_W]]),
`ifdef REGFILE_PARITY_EN
            .spar  (par[raddr[j*ADDR_W +: ADDR_W]]),
            .rperr (rperr[j]),
`endif
            .pend  (pend[raddr[j*ADDR_W +: ADDR_W]]),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .rdata (rdata[j*DATA_W +: DATA_W]),
            .rbusy (rbusy[j])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (parity checks when REGFILE_PARITY_EN is defined)
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [31:0] pend;
`ifdef REGFILE_PARITY_EN
    logic [1:0]  rperr;
`endif
    int total = 0;
    int bad = 0;
    regfile_mp dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
`ifdef REGFILE_PARITY_EN
        .rperr     (rperr),
`endif
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .pend      (pend)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1; we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
        iss_valid = 1'b0; iss_addr = '0;
        tick; tick;
        re = 2'b11; raddr = {5'd3, 5'd5};
        #1;
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_rbusy", {62'h0, rbusy}, 64'h0);
        chk("rst_pend", {32'h0, pend}, 64'h0);
        rst = 1'b0;
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
        #1;
        chk("r5_fwd", {32'h0, rdata[31:0]}, 64'hDEADBEEF);
        tick;
        we = '0;
        #1;
        chk("r5_stored", {32'h0, rdata[31:0]}, 64'hDEADBEEF);
        rst = 1'b1;
        #1;
        chk("rdata_in_rst", rdata, 64'h0);
        tick;
        rst = 1'b0;
        #1;
        chk("r5_after_rst", {32'h0, rdata[31:0]}, 64'h0);
        chk("pend_after_rst", {32'h0, pend}, 64'h0);
        we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h11}; raddr = {5'd0, 5'd3};
        #1;
        chk("fwd_same_cycle", {32'h0, rdata[31:0]}, 64'h11);
        tick;
        we = '0;
        #1;
        chk("fwd_next_cycle", {32'h0, rdata[31:0]}, 64'h11);
        we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h5555, 32'hAAAA}; raddr = {5'd7, 5'd3};
        #1;
        chk("coll_fwd", {32'h0, rdata[63:32]}, 64'h5555);
        tick;
        we = '0; raddr = {5'd7, 5'd7};
        #1;
        chk("coll_stored1", {32'h0, rdata[63:32]}, 64'h5555);
        chk("coll_stored0", {32'h0, rdata[31:0]}, 64'h5555);
        we = 2'b11; waddr = '0; wdata = {64{1'b1}}; iss_valid = 1'b1; iss_addr = 5'd0; raddr = '0;
        #1;
        chk("r0_write_rd", rdata, 64'h0);
        tick;
        we = '0; iss_valid = 1'b0;
        #1;
        chk("r0_rd", rdata, 64'h0);
        chk("r0_pend", {32'h0, pend}, 64'h0);
        chk("r0_rbusy", {62'h0, rbusy}, 64'h0);
        iss_valid = 1'b1; iss_addr = 5'd9;
        tick;
        iss_valid = 1'b0; raddr = {5'd3, 5'd9};
        #1;
        chk("iss_pend", {32'h0, pend}, 64'h200);
        chk("iss_rbusy", {62'h0, rbusy}, 64'h1);
        chk("iss_rd", {32'h0, rdata[31:0]}, 64'h0);
        re = 2'b10;
        #1;
        chk("re_off_rbusy", {62'h0, rbusy}, 64'h0);
        chk("re_off_rdata", {32'h0, rdata[31:0]}, 64'h0);
        re = 2'b11;
        we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h99};
        #1;
        chk("wb_rbusy", {62'h0, rbusy}, 64'h0);
        chk("wb_fwd", {32'h0, rdata[31:0]}, 64'h99);
        tick;
        we = '0;
        #1;
        chk("wb_pend", {32'h0, pend}, 64'h0);
        chk("wb_rd", {32'h0, rdata[31:0]}, 64'h99);
        iss_valid = 1'b1; iss_addr = 5'd9;
        we = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h77, 32'h0};
        tick;
        iss_valid = 1'b0; we = '0;
        #1;
        chk("iss_wb_pend", {32'h0, pend}, 64'h200);
        chk("iss_wb_rbusy", {62'h0, rbusy}, 64'h1);
        chk("iss_wb_rd", {32'h0, rdata[31:0]}, 64'h77);
`ifdef REGFILE_PARITY_EN
        we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h0F0F};
        tick;
        we = '0; raddr = {5'd3, 5'd4};
        #1;
        chk("par_ok", {62'h0, rperr}, 64'h0);
        dut.par[4] = ~dut.par[4];
        #1;
        chk("par_err", {62'h0, rperr}, 64'h1);
        we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h1};
        #1;
        chk("par_fwd", {62'h0, rperr}, 64'h0);
        tick;
        we = '0;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
